// File: rtl/line_raster_ctrl_pkg.sv
// Shared rasterizer constants: coordinate widths, error width, FSM encoding.
package line_raster_ctrl_pkg;

    localparam int XW_DEF = 10;   // x coordinate width (0..639)
    localparam int YW_DEF = 9;    // y coordinate width (0..479)
    localparam int ERRW   = 12;   // signed Bresenham error width

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

endpackage

// File: rtl/line_raster_ctrl_octant.sv
// Endpoint decode: absolute deltas, step directions and octant code.
module octant_decode
    import line_raster_ctrl_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] dx,
    output logic [YW-1:0] dy,
    output logic          sx_neg,
    output logic          sy_neg,
    output logic [2:0]    octant
);

    // Deltas are taken as magnitudes; direction lives in sx_neg/sy_neg.
    always_comb begin
        sx_neg = (x1 < x0);
        sy_neg = (y1 < y0);
        dx     = sx_neg ? (x0 - x1) : (x1 - x0);
        dy     = sy_neg ? (y0 - y1) : (y1 - y0);
        octant = {(ERRW'(dy) > ERRW'(dx)), sx_neg, sy_neg};
    end

endmodule

// File: rtl/line_raster_ctrl.sv
// Bresenham line rasterizer with valid/ready pixel output.
module line_raster_ctrl
    import line_raster_ctrl_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic          busy,
    output logic          done,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [2:0]    octant
);

    logic [1:0]             state;
    logic [XW-1:0]          ex0, ex1, cur_x;
    logic [YW-1:0]          ey0, ey1, cur_y;
    logic signed [ERRW-1:0] err, dx_r, dy_r, err_nxt;
    logic                   sx_neg_r, sy_neg_r;
    logic [2:0]             oct_r;

    logic [XW-1:0]          dec_dx;
    logic [YW-1:0]          dec_dy;
    logic                   dec_sxn, dec_syn;
    logic [2:0]             dec_oct;

    logic signed [ERRW:0]   e2, dx_e, dy_e;
    logic                   step_x, step_y, hshake, at_end;

    // Decode works on the latched endpoints so input changes after
    // acceptance cannot disturb the active line.
    octant_decode #(.XW(XW), .YW(YW)) u_dec (
        .x0     (ex0),
        .y0     (ey0),
        .x1     (ex1),
        .y1     (ey1),
        .dx     (dec_dx),
        .dy     (dec_dy),
        .sx_neg (dec_sxn),
        .sy_neg (dec_syn),
        .octant (dec_oct)
    );

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign pix_valid = (state == S_DRAW);
    assign pix_x     = cur_x;
    assign pix_y     = cur_y;
    assign octant    = oct_r;

    assign hshake = pix_valid && pix_ready;
    assign at_end = (cur_x == ex1) && (cur_y == ey1);

    // e2 = 2*err widened by one bit so the doubling cannot overflow.
    assign e2     = {err, 1'b0};
    assign dx_e   = {1'b0, dx_r};
    assign dy_e   = {1'b0, dy_r};
    assign step_x = (e2 > -dy_e);
    assign step_y = (e2 < dx_e);

    // Error update for one Bresenham step; both axes may step together.
    always_comb begin
        err_nxt = err;
        if (step_x) err_nxt = err_nxt - dy_r;
        if (step_y) err_nxt = err_nxt + dx_r;
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ex0      <= '0;
            ey0      <= '0;
            ex1      <= '0;
            ey1      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            err      <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
            oct_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ex0   <= x0;
                        ey0   <= y0;
                        ex1   <= x1;
                        ey1   <= y1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    dx_r     <= ERRW'(dec_dx);
                    dy_r     <= ERRW'(dec_dy);
                    err      <= ERRW'(dec_dx) - ERRW'(dec_dy);
                    sx_neg_r <= dec_sxn;
                    sy_neg_r <= dec_syn;
                    oct_r    <= dec_oct;
                    cur_x    <= ex0;
                    cur_y    <= ey0;
                    state    <= S_DRAW;
                end
                S_DRAW: begin
                    if (hshake) begin
                        if (at_end) begin
                            state <= S_FIN;
                        end else begin
                            err <= err_nxt;
                            if (step_x) cur_x <= sx_neg_r ? cur_x - XW'(1) : cur_x + XW'(1);
                            if (step_y) cur_y <= sy_neg_r ? cur_y - YW'(1) : cur_y + YW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster_ctrl.sv
// Self-checking bench for line_raster_ctrl: directed table, random lines
// against a queue-based reference, stall/start-ignore and reset sequences.
module tb_line_raster_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] in_x0, in_x1;
    logic [8:0] in_y0, in_y1;
    logic       busy, done, pix_valid, pix_ready;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [2:0] octant;

    int errors = 0;
    int checks = 0;

    line_raster_ctrl #(.XW(10), .YW(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x0        (in_x0),
        .y0        (in_y0),
        .x1        (in_x1),
        .y1        (in_y1),
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .octant    (octant)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, y0, x1, y1;
        int oct;
        int npix;
        int rdy;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk the line with plain integer Bresenham into queues.
    task automatic ref_line(input int ax0, ay0, ax1, ay1,
                            output int qx[$], output int qy[$]);
        int x, y, ddx, ddy, sx, sy, er, e2;
        qx = {};
        qy = {};
        x = ax0; y = ay0;
        ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ddy = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        sx = (ax1 >= ax0) ? 1 : -1;
        sy = (ay1 >= ay0) ? 1 : -1;
        er = ddx - ddy;
        for (int k = 0; k < 2000; k++) begin
            qx.push_back(x);
            qy.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * er;
            if (e2 > -ddy) begin er -= ddy; x += sx; end
            if (e2 < ddx)  begin er += ddx; y += sy; end
        end
    endtask

    // Drive one line with random back-pressure and score every handshake.
    task automatic run_line(input int ax0, ay0, ax1, ay1, input int exp_oct,
                            input int npix, input int rdy_pct, input string tag);
        int qx[$], qy[$], gx[$], gy[$];
        int cyc, last_hs, bad, px, py;
        bit stalled, fin;
        ref_line(ax0, ay0, ax1, ay1, qx, qy);
        @(negedge clk);
        in_x0 = 10'(ax0); in_y0 = 9'(ay0); in_x1 = 10'(ax1); in_y1 = 9'(ay1);
        start = 1'b1; pix_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " setup busy"}, int'(busy), 1);
        chk({tag, " setup valid"}, int'(pix_valid), 0);
        @(negedge clk);
        chk({tag, " first valid"}, int'(pix_valid), 1);
        chk({tag, " first x"}, int'(pix_x), ax0);
        chk({tag, " first y"}, int'(pix_y), ay0);
        cyc = 0; last_hs = -1; stalled = 0; fin = 0; px = 0; py = 0;
        while (!fin && cyc < 3000) begin
            if (done) begin
                chk({tag, " fin valid"}, int'(pix_valid), 0);
                chk({tag, " octant"}, int'(octant), exp_oct);
                fin = 1;
            end else if (pix_valid) begin
                if (stalled) begin
                    chk({tag, " hold x"}, int'(pix_x), px);
                    chk({tag, " hold y"}, int'(pix_y), py);
                end
                pix_ready = ($urandom_range(99) < rdy_pct);
                px = int'(pix_x); py = int'(pix_y);
                if (pix_ready) begin
                    gx.push_back(px); gy.push_back(py);
                    last_hs = cyc; stalled = 0;
                end else begin
                    stalled = 1;
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, " finished"}, int'(fin), 1);
        pix_ready = 1'b0;
        @(negedge clk);
        chk({tag, " done one cycle"}, int'(done), 0);
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " pixel count"}, gx.size(), npix);
        bad = 0;
        for (int i = 0; i < gx.size() && i < qx.size(); i++)
            if (gx[i] != qx[i] || gy[i] != qy[i]) bad++;
        chk({tag, " pixel mismatches"}, bad, 0);
        if (gx.size() > 0) begin
            chk({tag, " last x"}, gx[gx.size()-1], ax1);
            chk({tag, " last y"}, gy[gy.size()-1], ay1);
        end
        if (rdy_pct >= 100) begin
            chk({tag, " consecutive"}, last_hs, npix - 1);
            chk({tag, " done timing"}, cyc, last_hs + 1);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int rx0, ry0, rx1, ry1, rdx, rdy, roct;
        vecs[0] = '{0, 0, 3, 0, 3'b000, 4, 100};
        vecs[1] = '{10, 10, 7, 7, 3'b011, 4, 100};
        vecs[2] = '{5, 5, 5, 5, 3'b000, 1, 100};
        vecs[3] = '{0, 0, 639, 479, 3'b000, 640, 100};
        vecs[4] = '{3, 0, 1, 9, 3'b110, 10, 60};
        vecs[5] = '{20, 5, 0, 6, 3'b010, 21, 50};
        vecs[6] = '{0, 479, 639, 0, 3'b001, 640, 70};
        vecs[7] = '{7, 2, 7, 12, 3'b100, 11, 40};

        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
        in_x0 = '0; in_y0 = '0; in_x1 = '0; in_y1 = '0;
        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset valid", int'(pix_valid), 0);
        chk("reset pix_x", int'(pix_x), 0);
        chk("reset octant", int'(octant), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
                     vecs[i].oct, vecs[i].npix, vecs[i].rdy,
                     $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rx0 = $urandom_range(40); ry0 = $urandom_range(40);
            rx1 = $urandom_range(40); ry1 = $urandom_range(40);
            rdx = (rx1 > rx0) ? rx1 - rx0 : rx0 - rx1;
            rdy = (ry1 > ry0) ? ry1 - ry0 : ry0 - ry1;
            roct = ((rdy > rdx) ? 4 : 0) + ((rx1 < rx0) ? 2 : 0) + ((ry1 < ry0) ? 1 : 0);
            run_line(rx0, ry0, rx1, ry1, roct, ((rdx > rdy) ? rdx : rdy) + 1,
                     $urandom_range(30, 100), $sformatf("rnd%0d", i));
        end

        // Stall on the second pixel of (0,0)->(2,1); a start pulse meanwhile is ignored.
        @(negedge clk);
        in_x0 = 10'd0; in_y0 = 9'd0; in_x1 = 10'd2; in_y1 = 9'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("stall p0 x", int'(pix_x), 0);
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        in_x0 = 10'd100; in_y0 = 9'd100; in_x1 = 10'd50; in_y1 = 9'd60;
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            chk($sformatf("stall valid %0d", k), int'(pix_valid), 1);
            chk($sformatf("stall x %0d", k), int'(pix_x), 1);
            chk($sformatf("stall y %0d", k), int'(pix_y), 0);
            @(negedge clk);
        end
        start = 1'b0;
        chk("stall p1 x", int'(pix_x), 1);
        pix_ready = 1'b1;
        @(negedge clk);
        chk("stall p2 x", int'(pix_x), 2);
        chk("stall p2 y", int'(pix_y), 1);
        @(negedge clk);
        pix_ready = 1'b0;
        chk("stall done", int'(done), 1);
        chk("stall octant", int'(octant), 0);
        @(negedge clk);
        chk("stall idle", int'(busy), 0);

        // Reset in the middle of a long line.
        in_x0 = 10'd0; in_y0 = 9'd0; in_x1 = 10'd639; in_y1 = 9'd479;
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid valid", int'(pix_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst valid", int'(pix_valid), 0);
        chk("rst pix_x", int'(pix_x), 0);
        chk("rst pix_y", int'(pix_y), 0);
        chk("rst octant", int'(octant), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst no done", int'(done), 0);
        end
        #2 rst_n = 1'b1;
        pix_ready = 1'b0;
        in_x0 = 10'd5; in_y0 = 9'd5; in_x1 = 10'd5; in_y1 = 9'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post rst accept", int'(busy), 1);
        chk("post rst no done", int'(done), 0);
        @(negedge clk);
        chk("post rst valid", int'(pix_valid), 1);
        chk("post rst x", int'(pix_x), 5);
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        chk("post rst done", int'(done), 1);
        @(negedge clk);
        chk("post rst idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
